// File: rtl/fb_write_ctrl_if.sv
// Frame-buffer write-port bundle: address, pixel data and write strobe.
// The sequencer drives it as master; the buffer write port is the slave.
interface fb_write_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 3
);

  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;

  modport master (
    output wr_addr,
    output wr_data,
    output wr_en
  );

  modport slave (
    input wr_addr,
    input wr_data,
    input wr_en
  );

endinterface

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write sequencer: full-buffer clear sweep plus button cursor.
// Optional feature macro: BUTTON_DEBOUNCE_EN (debounce on both buttons).
module fb_write_ctrl #(
  parameter int AW         = 8,
  parameter int DW         = 3,
  parameter int DEB_CYCLES = 750000,
  parameter int DEB_W      = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   switch,
  input  logic            bntr,
  input  logic            bntl,
  input  logic            clr_req,
  fb_write_ctrl_if.master wr,
  output logic [AW-1:0]   cursor,
  output logic            busy
);

  if (DEB_W < 1 || DEB_W > 62 ||
      (64'(1) << DEB_W) <= 64'(DEB_CYCLES)) begin : g_bad_deb
    $error("fb_write_ctrl: DEB_W too narrow for DEB_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    PAINT
  } state_t;

  logic [DW-1:0] sw_m_q, sw_s_q;
  logic          br_m_q, br_s_q;
  logic          bl_m_q, bl_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_m_q <= '0;
      sw_s_q <= '0;
      br_m_q <= 1'b0;
      br_s_q <= 1'b0;
      bl_m_q <= 1'b0;
      bl_s_q <= 1'b0;
    end else begin
      sw_m_q <= switch;
      sw_s_q <= sw_m_q;
      br_m_q <= bntr;
      br_s_q <= br_m_q;
      bl_m_q <= bntl;
      bl_s_q <= bl_m_q;
    end
  end

  logic br_lvl, bl_lvl;

`ifdef BUTTON_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] DebLast = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] dbr_cnt_q, dbl_cnt_q;
  logic             dbr_q, dbl_q;

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbr_cnt_q <= '0;
      dbl_cnt_q <= '0;
      dbr_q     <= 1'b0;
      dbl_q     <= 1'b0;
    end else begin
      if (br_s_q == dbr_q) begin
        dbr_cnt_q <= '0;
      end else if (dbr_cnt_q == DebLast) begin
        dbr_q     <= br_s_q;
        dbr_cnt_q <= '0;
      end else begin
        dbr_cnt_q <= dbr_cnt_q + DEB_W'(1);
      end
      if (bl_s_q == dbl_q) begin
        dbl_cnt_q <= '0;
      end else if (dbl_cnt_q == DebLast) begin
        dbl_q     <= bl_s_q;
        dbl_cnt_q <= '0;
      end else begin
        dbl_cnt_q <= dbl_cnt_q + DEB_W'(1);
      end
    end
  end

  assign br_lvl = dbr_q;
  assign bl_lvl = dbl_q;
`else
  assign br_lvl = br_s_q;
  assign bl_lvl = bl_s_q;
`endif

  logic br_prev_q, bl_prev_q, clr_prev_q;
  logic ev_r_q, ev_l_q;
  logic ev_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_prev_q  <= 1'b0;
      bl_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      ev_r_q     <= 1'b0;
      ev_l_q     <= 1'b0;
    end else begin
      br_prev_q  <= br_lvl;
      bl_prev_q  <= bl_lvl;
      clr_prev_q <= clr_req;
      ev_r_q     <= br_lvl & ~br_prev_q;
      ev_l_q     <= bl_lvl & ~bl_prev_q;
    end
  end

  assign ev_clr = clr_req & ~clr_prev_q;

  state_t        state_q, state_d;
  logic          pend_clr_q, pend_clr_d;
  logic          pend_r_q, pend_r_d;
  logic          pend_l_q, pend_l_d;
  logic          svc_clr, svc_r, svc_l;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic [DW-1:0] data_q, data_d;
  logic          wen_q, wen_d;
  logic          busy_q, busy_d;

  // Outputs are computed for the next state so they register with it.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cursor_d = cursor_q;
    wen_d    = 1'b0;
    busy_d   = 1'b0;
    svc_clr  = 1'b0;
    svc_r    = 1'b0;
    svc_l    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_clr_q) begin
          svc_clr = 1'b1;
          state_d = CLEAR;
          addr_d  = '0;
          data_d  = sw_s_q;
          wen_d   = 1'b1;
          busy_d  = 1'b1;
        end else if (pend_r_q && pend_l_q) begin
          svc_r = 1'b1;
          svc_l = 1'b1;
        end else if (pend_r_q) begin
          svc_r    = 1'b1;
          state_d  = PAINT;
          cursor_d = cursor_q + AW'(1);
          addr_d   = cursor_q + AW'(1);
          data_d   = sw_s_q;
          wen_d    = 1'b1;
        end else if (pend_l_q) begin
          svc_l    = 1'b1;
          state_d  = PAINT;
          cursor_d = cursor_q - AW'(1);
          addr_d   = cursor_q - AW'(1);
          data_d   = sw_s_q;
          wen_d    = 1'b1;
        end
      end
      CLEAR: begin
        if (addr_q == '1) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_q + AW'(1);
          wen_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      PAINT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pend_clr_d = (pend_clr_q & ~svc_clr) | ev_clr;
    pend_r_d   = (pend_r_q & ~svc_r) | ev_r_q;
    pend_l_d   = (pend_l_q & ~svc_l) | ev_l_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pend_clr_q <= 1'b0;
      pend_r_q   <= 1'b0;
      pend_l_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cursor_q   <= '0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_clr_q <= pend_clr_d;
      pend_r_q   <= pend_r_d;
      pend_l_q   <= pend_l_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cursor_q   <= cursor_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
    end
  end

  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;
  assign wr.wr_en   = wen_q;
  assign cursor     = cursor_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl: clear sweep, cursor moves, reset abort.
// Debounce cases are exercised when BUTTON_DEBOUNCE_EN is defined.
module tb_fb_write_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 3;
  localparam int DEB = 8;
`ifdef BUTTON_DEBOUNCE_EN
  localparam int LAT = 5 + DEB;
`else
  localparam int LAT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] sw = '0;
  logic          bntr = 1'b0;
  logic          bntl = 1'b0;
  logic          clr_req = 1'b0;
  logic [AW-1:0] cursor;
  logic          busy;

  fb_write_ctrl_if #(.AW(AW), .DW(DW)) wif ();

  fb_write_ctrl #(
    .AW(AW),
    .DW(DW),
    .DEB_CYCLES(DEB),
    .DEB_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switch(sw),
    .bntr(bntr),
    .bntl(bntl),
    .clr_req(clr_req),
    .wr(wif),
    .cursor(cursor),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int busy_n = 0;
  int wa[$];
  int wd[$];
  int wc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wif.wr_en) begin
      wa.push_back(int'(wif.wr_addr));
      wd.push_back(int'(wif.wr_data));
      wc.push_back(cyc);
    end
    if (busy) busy_n <= busy_n + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic r, input logic l);
    @(negedge clk);
    bntr = r;
    bntl = l;
    repeat (LAT + 6) @(posedge clk);
    @(negedge clk);
    bntr = 1'b0;
    bntl = 1'b0;
    tick(LAT + 10);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  int m, b, nw, bad, span, last;
  logic hit;

  initial begin
    tick(3);
    chk("rst_wen", wif.wr_en, 0);
    chk("rst_addr", wif.wr_addr, 0);
    chk("rst_data", wif.wr_data, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(3);

    // full clear, colour 100
    sw = 3'b100;
    tick(3);
    m = wa.size();
    b = busy_n;
    pulse_clr();
    tick(300);
    nw = wa.size() - m;
    chk("clr_count", nw, 256);
    bad = 0;
    for (int i = 0; i < 256 && m + i < wa.size(); i++) begin
      if (wa[m+i] != i || wd[m+i] != 4) bad++;
    end
    chk("clr_seq", bad, 0);
    span = (nw > 0) ? wc[wa.size()-1] - wc[m] : -1;
    chk("clr_span", span, 255);
    chk("clr_busy_cyc", busy_n - b, 256);
    chk("clr_wen_after", wif.wr_en, 0);
    chk("clr_busy_after", busy, 0);
    chk("clr_cursor", cursor, 0);

    // left from 0 wraps to 255, with exact latency
    sw = 3'b010;
    tick(3);
    m = wa.size();
    @(negedge clk);
    bntl = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("l_pre_wen", wif.wr_en, 0);
    @(posedge clk);
    #1;
    chk("l_wen", wif.wr_en, 1);
    chk("l_addr", wif.wr_addr, 255);
    chk("l_data", wif.wr_data, 2);
    chk("l_cursor", cursor, 255);
    repeat (20) @(posedge clk);
    @(negedge clk);
    bntl = 1'b0;
    tick(LAT + 10);
    chk("l_writes", wa.size() - m, 1);

    // right from 255 wraps to 0
    sw = 3'b101;
    tick(3);
    m = wa.size();
    press(1'b1, 1'b0);
    chk("r_writes", wa.size() - m, 1);
    chk("r_cursor", cursor, 0);
    chk("r_addr", (wa.size() > m) ? wa[m] : -1, 0);
    chk("r_data", (wa.size() > m) ? wd[m] : -1, 5);

    // both buttons together cancel
    m = wa.size();
    press(1'b1, 1'b1);
    chk("both_writes", wa.size() - m, 0);
    chk("both_cursor", cursor, 0);

    // right press during a sweep waits for it to finish
    sw = 3'b001;
    tick(3);
    m = wa.size();
    pulse_clr();
    tick(103);
    @(negedge clk);
    bntr = 1'b1;
    sw = 3'b110;
    repeat (20) @(posedge clk);
    @(negedge clk);
    bntr = 1'b0;
    tick(300);
    nw = wa.size() - m;
    chk("mix_count", nw, 257);
    bad = 0;
    for (int i = 0; i < 256 && m + i < wa.size(); i++) begin
      if (wa[m+i] != i || wd[m+i] != 1) bad++;
    end
    chk("mix_clr_seq", bad, 0);
    last = wa.size() - 1;
    chk("mix_p_addr", (nw == 257) ? wa[last] : -1, 1);
    chk("mix_p_data", (nw == 257) ? wd[last] : -1, 6);
    chk("mix_gap", (nw == 257) ? wc[last] - wc[last-1] : -1, 2);
    chk("mix_cursor", cursor, 1);

    // reset in the middle of a sweep
    pulse_clr();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (wif.wr_en && wif.wr_addr == 8'd50) hit = 1'b1;
    end
    chk("rst_hit50", hit, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wen", wif.wr_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cursor", cursor, 0);
    m = wa.size();
    @(negedge clk);
    rst = 1'b1;
    tick(300);
    chk("arst_quiet", wa.size() - m, 0);

`ifdef BUTTON_DEBOUNCE_EN
    // 5-cycle glitch is rejected, 20-cycle press moves once
    m = wa.size();
    @(negedge clk);
    bntr = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bntr = 1'b0;
    tick(40);
    chk("deb_glitch_wr", wa.size() - m, 0);
    chk("deb_glitch_cur", cursor, 0);
    m = wa.size();
    @(negedge clk);
    bntr = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    bntr = 1'b0;
    tick(40);
    chk("deb_press_wr", wa.size() - m, 1);
    chk("deb_press_cur", cursor, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
